dsp_mac_slice: RTL and testbench
================================

# dsp_mac_slice

Parametrised, fully pipelined pre-add / multiply / post-add (MAC) slice, the next generation of the team's DSP48A1-style arithmetic block. It generalises the data widths and adds valid tagging, a signed pre-adder that cannot overflow, a selectable accumulate/C/cascade post-adder, and optional saturation with an overflow flag. Slices chain through PCIN/PCOUT to build filters and dot-product engines.

## Interface
- AW, 18, width of A (signed)
- BW, 18, width of B and D (signed)
- PW, 48, width of C, PCIN, P, PCOUT (signed); legal only if PW >= AW+BW+1
- clk  in  1  clock, all registers on rising edge
- RSTN  in  1  reset, asynchronous assert, active-low; deassertion synchronous to clk
- CE  in  1  global clock enable; low freezes every pipeline register
- IN_VALID  in  1  input beat qualifier
- A  in  AW  multiplier operand
- B  in  BW  pre-adder operand
- D  in  BW  pre-adder operand
- C  in  PW  post-adder operand
- PCIN  in  PW  cascade input from the upstream slice's PCOUT
- CARRYIN  in  1  carry into the post-adder
- OPMODE  in  6  [0] pre-adder enable, [1] pre-subtract, [3:2] Z select, [4] post-subtract, [5] saturate enable
- P  out  PW  result
- PCOUT  out  PW  cascade output, always equal to P
- M  out  AW+BW+1  stage-2 product register, for debug
- OUT_VALID  out  1  P holds a new result this cycle
- OVF  out  1  overflow flag for the current P

## Operation
- All arithmetic is signed two's complement. Operands are sign-extended before every add.
- Stage 1 registers A, B, D, C, CARRYIN, OPMODE and IN_VALID. These fields travel with the beat; no OPMODE is ever applied to a different beat.
- Pre-adder, computed at BW+1 bits so it never wraps:
  - OPMODE[0]=0: value is B.
  - OPMODE[0]=1, OPMODE[1]=0: value is D+B.
  - OPMODE[0]=1, OPMODE[1]=1: value is D-B.
- Stage 2: M <= A1 × pre-adder value, AW+BW+1 bits. C, CARRYIN, OPMODE and valid advance alongside.
- Z select (OPMODE[3:2]):
  - 00: zero.
  - 01: current P (accumulate).
  - 10: C from stage 2.
  - 11: PCIN, sampled live at stage 3.
- Post-adder, computed at PW+1 bits:
  - OPMODE[4]=0: S = Z + sext(M) + CARRYIN.
  - OPMODE[4]=1: S = Z - sext(M) - CARRYIN.
- Overflow: S lies outside [-2^(PW-1), 2^(PW-1)-1].
  - OPMODE[5]=1: P clamps to the nearest bound.
  - OPMODE[5]=0: P takes S[PW-1:0], i.e. wraps.
  - OVF is set in both cases.
- Stage 3 update: P and OVF load only when CE=1 and stage-2 valid=1. Otherwise P and OVF hold.
- Bubbles (IN_VALID=0) still flow through stages 1 and 2 but never modify P.
- Accumulate reads the P register itself. Back-to-back valid beats with Z=01 therefore accumulate every beat with no hazard.

## Timing
- Latency is 3 enabled clocks from a valid input beat to its OUT_VALID=1, P update and OVF update.
- Throughput is one beat per clock.
- OUT_VALID is a single-cycle pulse per beat. It is 0 whenever CE=0.
- CE=0 holds every register, including the valid pipeline. Latency stretches by the number of stalled cycles; no beat is lost or duplicated.
- Reset, asynchronous on RSTN=0 at any time, including mid-stream:
  - All pipeline registers clear to 0.
  - P=0, PCOUT=0, M=0, OUT_VALID=0, OVF=0.
  - Beats in flight are discarded.
  - The first input accepted after release appears 3 enabled clocks later.
- PCIN has no input register. It must come straight from the upstream PCOUT, so a cascaded chain adds one clock of skew per slice.
- If upstream CE and downstream CE differ, the system integrator keeps the chain aligned.

## Test plan
- Reset: stream valid beats, drop RSTN low mid-stream -> P, M, OUT_VALID, OVF read 0 in the same cycle. After release, the next beat (A=2, B=3, OPMODE=0) gives P=6 exactly 3 clocks later.
- Pre-add: A=3, B=5, D=7, OPMODE=000001 -> M=36, and P=36 with OUT_VALID=1 on clock 3.
- Pre-subtract: A=4, B=5, D=2, OPMODE=000011 -> P=-12. Repeat with D=-131072, B=131071 (BW=18) -> pre-add gives -262143 without wrap.
- Accumulate:
  - Beat 1: A=1, B=10, Z=00.
  - Beats 2-4, back-to-back: Z=01, CARRYIN=1.
  - Expect P=10, 21, 32, 43 on four consecutive clocks.
- Saturation: C=2^47-1, A=1, B=1, Z=10.
  - OPMODE[5]=1 -> P=2^47-1, OVF=1.
  - OPMODE[5]=0 -> P=-2^47, OVF=1.
- Stall: eight valid beats with CE=0 for 2 cycles after beat 3 -> all eight results appear in order, each exactly once, and OUT_VALID=0 during the stall.

Source files
------------

// File: rtl/dsp_mac_slice.sv
// dsp_mac_slice: three-stage pipelined MAC slice.
// Data path: signed pre-adder, then multiplier, then post-adder with
// zero/accumulate/C/cascade Z select, plus optional saturation.
// Slices chain through PCOUT -> PCIN.
//
// Valid semantics: IN_VALID qualifies the beat on A/B/D/C/CARRYIN/OPMODE
// at a rising clk edge with CE=1. There is no back-pressure. The beat
// appears on P exactly three enabled edges later, and OUT_VALID pulses
// for one enabled cycle. OUT_VALID is forced low while CE=0; a pending
// pulse is shown once CE returns high.
module dsp_mac_slice #(
    parameter int AW = 18,
    parameter int BW = 18,
    parameter int PW = 48
) (
    input  logic              clk,
    input  logic              RSTN,
    input  logic              CE,
    input  logic              IN_VALID,
    input  logic [AW-1:0]     A,
    input  logic [BW-1:0]     B,
    input  logic [BW-1:0]     D,
    input  logic [PW-1:0]     C,
    input  logic [PW-1:0]     PCIN,
    input  logic              CARRYIN,
    input  logic [5:0]        OPMODE,
    output logic [PW-1:0]     P,
    output logic [PW-1:0]     PCOUT,
    output logic [AW+BW:0]    M,
    output logic              OUT_VALID,
    output logic              OVF
);

    localparam int MW = AW + BW + 1;

    // stage 1 registers
    logic [AW-1:0] a1;
    logic [BW-1:0] b1;
    logic [BW-1:0] d1;
    logic [PW-1:0] c1;
    logic          cin1;
    logic [5:0]    op1;
    logic          v1;

    // stage 2 registers; op2 keeps OPMODE[5:2] = {sat, post_sub, z_sel[1:0]}
    logic [MW-1:0] m_reg;
    logic [PW-1:0] c2;
    logic          cin2;
    logic [3:0]    op2;
    logic          v2;

    // stage 3 registers
    logic [PW-1:0] p_reg;
    logic          ovf_reg;
    logic          out_valid_r;

    // combinational intermediates
    logic [BW:0]   b_ext;
    logic [BW:0]   d_ext;
    logic [BW:0]   pre;
    logic [MW-1:0] a_sx;
    logic [MW-1:0] pre_sx;
    logic [MW-1:0] prod;
    logic [PW:0]   z_ext;
    logic [PW:0]   m_ext;
    logic [PW:0]   cin_ext;
    logic [PW:0]   sum;
    logic          ovf_next;
    logic [PW-1:0] p_next;

    // Stage 1: capture the beat and everything that travels with it
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            a1   <= '0;
            b1   <= '0;
            d1   <= '0;
            c1   <= '0;
            cin1 <= 1'b0;
            op1  <= '0;
            v1   <= 1'b0;
        end else if (CE) begin
            a1   <= A;
            b1   <= B;
            d1   <= D;
            c1   <= C;
            cin1 <= CARRYIN;
            op1  <= OPMODE;
            v1   <= IN_VALID;
        end
    end

    // Pre-adder at BW+1 bits so D+B and D-B never wrap
    always_comb begin
        b_ext = {b1[BW-1], b1};
        d_ext = {d1[BW-1], d1};
        pre   = b_ext;
        if (op1[0]) begin
            pre = op1[1] ? (d_ext - b_ext) : (d_ext + b_ext);
        end
    end

    // Signed product: both operands sign-extended to the full product width,
    // so the low MW bits of the unsigned product are the exact signed result.
    always_comb begin
        a_sx   = {{(BW + 1){a1[AW-1]}}, a1};
        pre_sx = {{AW{pre[BW]}}, pre};
        prod   = a_sx * pre_sx;
    end

    // Stage 2: product register plus the beat's remaining fields
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            m_reg <= '0;
            c2    <= '0;
            cin2  <= 1'b0;
            op2   <= '0;
            v2    <= 1'b0;
        end else if (CE) begin
            m_reg <= prod;
            c2    <= c1;
            cin2  <= cin1;
            op2   <= op1[5:2];
            v2    <= v1;
        end
    end

    // Post-adder at PW+1 bits, with overflow detection and optional clamp
    always_comb begin
        case (op2[1:0])
            2'b00:   z_ext = '0;
            2'b01:   z_ext = {p_reg[PW-1], p_reg};
            2'b10:   z_ext = {c2[PW-1], c2};
            default: z_ext = {PCIN[PW-1], PCIN};
        endcase
        m_ext   = {{(PW - AW - BW){m_reg[MW-1]}}, m_reg};
        cin_ext = {{PW{1'b0}}, cin2};
        sum     = op2[2] ? (z_ext - m_ext - cin_ext) : (z_ext + m_ext + cin_ext);
        // The two top bits disagree exactly when S is outside the PW-bit range
        ovf_next = sum[PW] ^ sum[PW-1];
        p_next   = sum[PW-1:0];
        if (ovf_next && op2[3]) begin
            p_next = sum[PW] ? {1'b1, {(PW - 1){1'b0}}} : {1'b0, {(PW - 1){1'b1}}};
        end
    end

    // Stage 3: P/OVF update only on an enabled valid beat; bubbles leave P alone
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            p_reg       <= '0;
            ovf_reg     <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (CE) begin
            out_valid_r <= v2;
            if (v2) begin
                p_reg   <= p_next;
                ovf_reg <= ovf_next;
            end
        end
    end

    assign P         = p_reg;
    assign PCOUT     = p_reg;
    assign M         = m_reg;
    assign OVF       = ovf_reg;
    assign OUT_VALID = out_valid_r & CE;

endmodule

// File: tb/tb_dsp_mac_slice.sv
// Self-checking bench for dsp_mac_slice (AW=18, BW=18, PW=48).
module tb_dsp_mac_slice;

    localparam logic [47:0] MAXV     = 48'h7FFF_FFFF_FFFF;
    localparam logic [47:0] MINV     = 48'h8000_0000_0000;
    localparam logic [47:0] PCIN_VAL = 48'd1000;

    logic        clk = 1'b0;
    logic        RSTN;
    logic        CE;
    logic        IN_VALID;
    logic [17:0] A;
    logic [17:0] B;
    logic [17:0] D;
    logic [47:0] C;
    logic [47:0] PCIN;
    logic        CARRYIN;
    logic [5:0]  OPMODE;
    logic [47:0] P;
    logic [47:0] PCOUT;
    logic [36:0] M;
    logic        OUT_VALID;
    logic        OVF;

    dsp_mac_slice #(.AW(18), .BW(18), .PW(48)) dut (
        .clk(clk), .RSTN(RSTN), .CE(CE), .IN_VALID(IN_VALID),
        .A(A), .B(B), .D(D), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN),
        .OPMODE(OPMODE), .P(P), .PCOUT(PCOUT), .M(M),
        .OUT_VALID(OUT_VALID), .OVF(OVF)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [48:0] exp_q[$];   // {ovf, p}
    logic [47:0] model_p = '0;

    typedef struct {
        logic [17:0] a;
        logic [17:0] b;
        logic [17:0] d;
        logic [47:0] c;
        logic        cin;
        logic [5:0]  op;
        logic [47:0] exp_p;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 64-bit integer arithmetic, range check against PW=48.
    function automatic logic [48:0] model(input logic [17:0] a, input logic [17:0] b,
                                          input logic [17:0] d, input logic [47:0] c,
                                          input logic cin, input logic [5:0] op);
        longint av, bv, dv, pre, prod, z, s;
        logic [63:0] t;
        logic [47:0] r;
        logic ov;
        av = longint'($signed(a));
        bv = longint'($signed(b));
        dv = longint'($signed(d));
        pre = op[0] ? (op[1] ? dv - bv : dv + bv) : bv;
        prod = av * pre;
        case (op[3:2])
            2'b00:   z = 0;
            2'b01:   z = longint'($signed(model_p));
            2'b10:   z = longint'($signed(c));
            default: z = longint'($signed(PCIN_VAL));
        endcase
        s = op[4] ? (z - prod - longint'(cin)) : (z + prod + longint'(cin));
        t = s;
        r = t[47:0];
        ov = 1'b0;
        if (s > longint'($signed(MAXV))) begin
            ov = 1'b1;
            if (op[5]) r = MAXV;
        end else if (s < longint'($signed(MINV))) begin
            ov = 1'b1;
            if (op[5]) r = MINV;
        end
        model_p = r;
        return {ov, r};
    endfunction

    // driver tasks
    task automatic send(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                        input logic [47:0] c, input logic cin, input logic [5:0] op,
                        input logic [48:0] exp);
        @(posedge clk);
        #1;
        A = a; B = b; D = d; C = c; CARRYIN = cin; OPMODE = op;
        IN_VALID = 1'b1;
        exp_q.push_back(exp);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d expected=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // scoreboard: pop and compare on every visible OUT_VALID
    always @(negedge clk) begin
        logic [48:0] e;
        if (RSTN === 1'b1) begin
            if (CE === 1'b0) begin
                checks++;
                if (OUT_VALID !== 1'b0) begin
                    failures++;
                    $display("FAIL out_valid_during_stall actual=%b expected=0", OUT_VALID);
                end
            end
            if (OUT_VALID === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out P=%0h expected=no_output", P);
                end else begin
                    e = exp_q.pop_front();
                    chk("p", P, e[47:0]);
                    chk("ovf", {47'd0, OVF}, {47'd0, e[48]});
                    chk("pcout", PCOUT, e[47:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expected=finish actual=timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [48:0] e;
        RSTN = 1'b0; CE = 1'b0; IN_VALID = 1'b0;
        A = '0; B = '0; D = '0; C = '0; CARRYIN = 1'b0; OPMODE = '0;
        PCIN = PCIN_VAL;

        tbl[0]  = '{18'd3, 18'd5, 18'd7, 48'd0, 1'b0, 6'b000001, 48'd36, 1'b0};
        tbl[1]  = '{18'd4, 18'd5, 18'd2, 48'd0, 1'b0, 6'b000011, -48'sd12, 1'b0};
        tbl[2]  = '{18'd1, 18'd131071, -18'sd131072, 48'd0, 1'b0, 6'b000011, -48'sd262143, 1'b0};
        tbl[3]  = '{18'd1, 18'd10, 18'd0, 48'd0, 1'b0, 6'b000000, 48'd10, 1'b0};
        tbl[4]  = '{18'd1, 18'd10, 18'd0, 48'd0, 1'b1, 6'b000100, 48'd21, 1'b0};
        tbl[5]  = '{18'd1, 18'd10, 18'd0, 48'd0, 1'b1, 6'b000100, 48'd32, 1'b0};
        tbl[6]  = '{18'd1, 18'd10, 18'd0, 48'd0, 1'b1, 6'b000100, 48'd43, 1'b0};
        tbl[7]  = '{18'd1, 18'd1, 18'd0, MAXV, 1'b0, 6'b101000, MAXV, 1'b1};
        tbl[8]  = '{18'd1, 18'd1, 18'd0, MAXV, 1'b0, 6'b001000, MINV, 1'b1};
        tbl[9]  = '{18'd3, 18'd4, 18'd0, 48'd100, 1'b1, 6'b011000, 48'd87, 1'b0};
        tbl[10] = '{18'd1, 18'd1, 18'd0, MINV, 1'b0, 6'b111000, MINV, 1'b1};
        tbl[11] = '{-18'sd2, 18'd7, 18'd0, 48'd0, 1'b0, 6'b001100, 48'd986, 1'b0};
        tbl[12] = '{-18'sd131072, -18'sd131072, -18'sd131072, 48'd0, 1'b0, 6'b000001,
                    48'd34359738368, 1'b0};
        tbl[13] = '{18'd1000, 18'd1000, 18'd0, 48'd0, 1'b0, 6'b010100,
                    48'd34358738368, 1'b0};

        // reset state
        #12;
        chk("reset_p", P, 48'd0);
        chk("reset_m", {11'd0, M}, 48'd0);
        chk("reset_out_valid", {47'd0, OUT_VALID}, 48'd0);
        chk("reset_ovf", {47'd0, OVF}, 48'd0);
        @(negedge clk);
        RSTN = 1'b1;
        CE = 1'b1;

        // pre-add with M debug output and exact latency
        send(18'd3, 18'd5, 18'd7, 48'd0, 1'b0, 6'b000001, {1'b0, 48'd36});
        @(posedge clk); #1; IN_VALID = 1'b0;
        @(posedge clk); #1;
        chk("preadd_m", {11'd0, M}, 48'd36);
        chk("preadd_early_valid", {47'd0, OUT_VALID}, 48'd0);
        @(posedge clk); #1;
        chk("preadd_valid_clk3", {47'd0, OUT_VALID}, 48'd1);
        chk("preadd_p_clk3", P, 48'd36);
        model_p = 48'd36;
        drain();

        // table-driven vectors, back to back
        for (int i = 0; i < 14; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].c, tbl[i].cin, tbl[i].op,
                 {tbl[i].exp_ovf, tbl[i].exp_p});
            model_p = tbl[i].exp_p;
        end
        idle();
        drain();

        // stall: eight beats, CE low for two cycles after beat 3
        for (int i = 0; i < 8; i++) begin
            logic [17:0] av;
            logic [17:0] bv;
            av = 18'(i + 1);
            bv = 18'(i + 2);
            e = model(av, bv, 18'd0, 48'd0, 1'b0, 6'b000000);
            send(av, bv, 18'd0, 48'd0, 1'b0, 6'b000000, e);
            if (i == 2) begin
                @(posedge clk); #1;
                CE = 1'b0; IN_VALID = 1'b0;
                #1;
                chk("stall_out_valid_1", {47'd0, OUT_VALID}, 48'd0);
                @(posedge clk); #2;
                chk("stall_out_valid_2", {47'd0, OUT_VALID}, 48'd0);
                @(posedge clk); #1;
                CE = 1'b1;
            end
        end
        idle();
        drain();

        // random beats with bubbles and occasional stalls
        for (int i = 0; i < 60; i++) begin
            logic [17:0] ra, rb, rd;
            logic [47:0] rc;
            logic rcin;
            logic [5:0] rop;
            if ($urandom_range(0, 5) == 0) begin
                @(posedge clk); #1; CE = 1'b0; IN_VALID = 1'b0;
                @(posedge clk); #1; CE = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
                ra = 18'($urandom());
                rb = 18'($urandom());
                rd = 18'($urandom());
                rc = {16'($urandom()), 32'($urandom())};
                rcin = 1'($urandom());
                rop = 6'($urandom());
                e = model(ra, rb, rd, rc, rcin, rop);
                send(ra, rb, rd, rc, rcin, rop, e);
            end
        end
        idle();
        drain();

        // reset mid-stream
        for (int i = 0; i < 5; i++) begin
            e = model(18'(i + 3), 18'd5, 18'd0, 48'd0, 1'b0, 6'b000000);
            send(18'(i + 3), 18'd5, 18'd0, 48'd0, 1'b0, 6'b000000, e);
        end
        #2;
        RSTN = 1'b0;
        IN_VALID = 1'b0;
        #1;
        chk("midreset_p", P, 48'd0);
        chk("midreset_m", {11'd0, M}, 48'd0);
        chk("midreset_out_valid", {47'd0, OUT_VALID}, 48'd0);
        chk("midreset_ovf", {47'd0, OVF}, 48'd0);
        exp_q.delete();
        model_p = '0;
        repeat (2) @(negedge clk);
        RSTN = 1'b1;

        // first beat after release: exactly three clocks
        send(18'd2, 18'd3, 18'd0, 48'd0, 1'b0, 6'b000000, {1'b0, 48'd6});
        @(posedge clk); #1; IN_VALID = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_early_valid", {47'd0, OUT_VALID}, 48'd0);
        @(posedge clk); #1;
        chk("post_reset_valid_clk3", {47'd0, OUT_VALID}, 48'd1);
        chk("post_reset_p_clk3", P, 48'd6);
        drain();
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
